sound_player: RTL

Plays the short game sound effects requested by the game-state controller. Consumes the `playsound`/`soundselector` request pair, sequences a fixed per-sound list of notes, and drives a single-bit square-wave `speaker` output to the board's piezo/amp pin. Sits between the game-state FSM and the speaker I/O pad.

---
 rtl/sound_player.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sound_player.sv
// Game sound-effect sequencer: plays a fixed list of square-wave notes per request code
// and drives a single-bit speaker output.
module sound_player #(
    parameter int unsigned NOTE_CYCLES = 1_200_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       playsound,
    input  logic [1:0] soundselector,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] note_idx
);

    localparam int unsigned DUR_W = (NOTE_CYCLES > 2) ? $clog2(NOTE_CYCLES) : 1;
    localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    localparam logic [1:0] SND_UI_PRESS    = 2'd0;
    localparam logic [1:0] SND_NEXTLEVEL   = 2'd1;
    localparam logic [1:0] SND_CRASH       = 2'd2;
    localparam logic [1:0] SND_CELEBRATION = 2'd3;

    localparam logic [15:0] HALF_C5 = 16'd11472;
    localparam logic [15:0] HALF_E5 = 16'd9104;
    localparam logic [15:0] HALF_G5 = 16'd7653;
    localparam logic [15:0] HALF_C6 = 16'd5731;
    localparam logic [15:0] HALF_A3 = 16'd27273;
    localparam logic [15:0] HALF_F3 = 16'd34286;

    logic [0:0]       state, state_d;
    logic             prev_play;
    logic [1:0]       sel, sel_d;
    logic [15:0]      tone_cnt, tone_cnt_d;
    logic [DUR_W-1:0] dur_cnt, dur_cnt_d;
    logic [1:0]       note_idx_d;
    logic             sq, sq_d;

    logic [15:0] half;
    logic [1:0]  last_idx;
    logic        req;
    logic        tone_wrap;
    logic        note_end;
    logic        last_note;

    // Half-period of the current note and index of the final note for the latched sound.
    always_comb begin
        half     = HALF_C6;
        last_idx = 2'd0;
        unique case (sel)
            SND_UI_PRESS: begin
                half     = HALF_C6;
                last_idx = 2'd0;
            end
            SND_NEXTLEVEL: begin
                last_idx = 2'd2;
                unique case (note_idx)
                    2'd0:    half = HALF_C5;
                    2'd1:    half = HALF_E5;
                    default: half = HALF_G5;
                endcase
            end
            SND_CRASH: begin
                last_idx = 2'd1;
                half     = (note_idx == 2'd0) ? HALF_A3 : HALF_F3;
            end
            SND_CELEBRATION: begin
                last_idx = 2'd3;
                unique case (note_idx)
                    2'd0: half = HALF_C5;
                    2'd1: half = HALF_E5;
                    2'd2: half = HALF_G5;
                    2'd3: half = HALF_C6;
                endcase
            end
        endcase
    end

    assign req       = playsound & ~prev_play;
    assign tone_wrap = (tone_cnt == half - 16'd1);
    assign note_end  = (dur_cnt == DUR_LAST);
    assign last_note = (note_idx == last_idx);

    always_comb begin
        state_d    = state;
        sel_d      = sel;
        tone_cnt_d = tone_cnt;
        dur_cnt_d  = dur_cnt;
        note_idx_d = note_idx;
        sq_d       = sq;

        if (req) begin
            // A new request always restarts from note 0, preempting any sound in progress.
            state_d    = PLAY;
            sel_d      = soundselector;
            tone_cnt_d = '0;
            dur_cnt_d  = '0;
            note_idx_d = '0;
            sq_d       = 1'b0;
        end else if (state == PLAY) begin
            if (note_end) begin
                tone_cnt_d = '0;
                dur_cnt_d  = '0;
                sq_d       = 1'b0;
                if (last_note) begin
                    state_d = IDLE;
                end else begin
                    note_idx_d = note_idx + 2'd1;
                end
            end else begin
                dur_cnt_d = dur_cnt + DUR_W'(1);
                if (tone_wrap) begin
                    tone_cnt_d = '0;
                    sq_d       = ~sq;
                end else begin
                    tone_cnt_d = tone_cnt + 16'd1;
                end
            end
        end else begin
            tone_cnt_d = '0;
            dur_cnt_d  = '0;
            sq_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prev_play <= 1'b0;
            sel       <= 2'd0;
            tone_cnt  <= '0;
            dur_cnt   <= '0;
            note_idx  <= 2'd0;
            sq        <= 1'b0;
        end else begin
            state     <= state_d;
            prev_play <= playsound;
            sel       <= sel_d;
            tone_cnt  <= tone_cnt_d;
            dur_cnt   <= dur_cnt_d;
            note_idx  <= note_idx_d;
            sq        <= sq_d;
        end
    end

    assign busy    = (state == PLAY);
    assign speaker = sq & ~mute;

endmodule
